// File: rtl/dkong_input_conditioner_if.sv
// Bundle of cabinet-control signals between the board pins and the input conditioner.
// Latency: none, plain wires.
// Backpressure: none; levels and strobes only.
// Ports: raw_in (pins -> conditioner), cond_out/rise_stb/fall_stb/any_active (conditioner -> system).
interface dkong_input_conditioner_if #(
  parameter int NUM_CH = 13
);
  logic [NUM_CH-1:0] raw_in;
  logic [NUM_CH-1:0] cond_out;
  logic [NUM_CH-1:0] rise_stb;
  logic [NUM_CH-1:0] fall_stb;
  logic              any_active;

  // master: the pin side that drives raw switch levels and consumes conditioned results
  modport master (
    output raw_in,
    input  cond_out, rise_stb, fall_stb, any_active
  );

  // slave: the conditioner itself
  modport slave (
    input  raw_in,
    output cond_out, rise_stb, fall_stb, any_active
  );
endinterface

// File: rtl/dkong_input_conditioner.sv
// Cabinet-control conditioner: polarity fix, synchroniser, debounce, edge strobes, optional coin one-shot.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES edges to accept a clean edge, strobes/outputs one edge later.
// Backpressure: none; free-running, every output is a registered level or single-cycle strobe.
// Ports: masterclk, rst_n (async active-low), io.raw_in (async switches),
//        io.cond_out / io.rise_stb / io.fall_stb / io.any_active (registered results).
module dkong_input_conditioner #(
  parameter int                NUM_CH          = 13,
  parameter int                SYNC_STAGES     = 2,
  parameter logic [15:0]       DEBOUNCE_CYCLES = 16'd5000,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = '0,
  parameter logic [NUM_CH-1:0] PULSE_CH_MASK   = '0,
  parameter int                PULSE_CYCLES    = 16
) (
  input logic                      masterclk,
  input logic                      rst_n,
  dkong_input_conditioner_if.slave io
);

  localparam int DB = int'(DEBOUNCE_CYCLES);
  // A zero-cycle debounce still keeps a 1-bit counter so the array is never zero-width.
  localparam int CW = (DB > 0) ? $clog2(DB + 1) : 1;
  localparam int PW = $clog2(PULSE_CYCLES + 1);

  // Inversion happens ahead of the first flop, so every later stage sees active-high.
  logic [NUM_CH-1:0] norm;
  logic [NUM_CH-1:0] syn;
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];

  logic [NUM_CH-1:0] stable_q, stable_d;
  logic [NUM_CH-1:0] stable_dly_q;
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];

  logic [NUM_CH-1:0] press, rel;
  logic [PW-1:0]     pcnt_q [NUM_CH];
  logic [PW-1:0]     pcnt_d [NUM_CH];
  logic [NUM_CH-1:0] cond_q, cond_d;
  logic [NUM_CH-1:0] rise_q, fall_q;
  logic              any_q;

  assign norm = io.raw_in ^ ACTIVE_LOW_MASK;
  assign syn  = sync_q[SYNC_STAGES-1];

  // Debounce: a change is accepted only after DB consecutive cycles of disagreement;
  // any cycle of agreement throws the partial count away.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (DB == 0) begin
        stable_d[i] = syn[i];
      end else if (syn[i] != stable_q[i]) begin
        if (cnt_q[i] == CW'(DB - 1)) begin
          stable_d[i] = syn[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // stable_q changed on the previous edge exactly when it differs from its delayed copy.
  assign press = stable_q & ~stable_dly_q;
  assign rel   = ~stable_q & stable_dly_q;

  // Pulse channels load only from idle, so a press landing inside a running pulse is dropped
  // and a held switch yields one pulse (the next press needs an accepted release first).
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pcnt_d[i] = '0;
      cond_d[i] = stable_q[i];
      if (PULSE_CH_MASK[i]) begin
        if (press[i] && (pcnt_q[i] == '0)) begin
          pcnt_d[i] = PW'(PULSE_CYCLES);
        end else if (pcnt_q[i] != '0) begin
          pcnt_d[i] = pcnt_q[i] - PW'(1);
        end
        // Output follows the counter value being loaded this edge.
        cond_d[i] = (press[i] && (pcnt_q[i] == '0)) || (pcnt_q[i] > PW'(1));
      end
    end
  end

  always_ff @(posedge masterclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        pcnt_q[i] <= '0;
      end
      stable_q     <= '0;
      stable_dly_q <= '0;
      cond_q       <= '0;
      rise_q       <= '0;
      fall_q       <= '0;
      any_q        <= 1'b0;
    end else begin
      sync_q[0] <= norm;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        pcnt_q[i] <= pcnt_d[i];
      end
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cond_q       <= cond_d;
      rise_q       <= press;
      fall_q       <= rel;
      any_q        <= |stable_q;
    end
  end

  assign io.cond_out   = cond_q;
  assign io.rise_stb   = rise_q;
  assign io.fall_stb   = fall_q;
  assign io.any_active = any_q;

endmodule

// File: tb/tb_dkong_input_conditioner.sv
// Bench for dkong_input_conditioner: three instances (debounced/coin, active-low, bypassed debounce).
// Expected strobe events are queued when stimulus is driven and matched against observed strobes.
// Level checks (cond_out, any_active, pulse width) are made inline in each scenario task.
module tb_dkong_input_conditioner;
  localparam int N = 13;

  typedef struct packed {
    logic [31:0]  cyc;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } ev_t;

  logic masterclk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   mon_sel = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  dkong_input_conditioner_if #(.NUM_CH(N)) if_a ();
  dkong_input_conditioner_if #(.NUM_CH(N)) if_b ();
  dkong_input_conditioner_if #(.NUM_CH(N)) if_c ();

  dkong_input_conditioner #(
    .NUM_CH(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16'd8),
    .ACTIVE_LOW_MASK(13'h0000), .PULSE_CH_MASK(13'h1000), .PULSE_CYCLES(16)
  ) dut_a (.masterclk(masterclk), .rst_n(rst_n), .io(if_a));

  dkong_input_conditioner #(
    .NUM_CH(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16'd8),
    .ACTIVE_LOW_MASK(13'h1FFF), .PULSE_CH_MASK(13'h0000), .PULSE_CYCLES(16)
  ) dut_b (.masterclk(masterclk), .rst_n(rst_n), .io(if_b));

  dkong_input_conditioner #(
    .NUM_CH(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16'd0),
    .ACTIVE_LOW_MASK(13'h0000), .PULSE_CH_MASK(13'h0000), .PULSE_CYCLES(16)
  ) dut_c (.masterclk(masterclk), .rst_n(rst_n), .io(if_c));

  always #5 masterclk = ~masterclk;
  always @(posedge masterclk) cyc <= cyc + 1;

  // Record every strobe event of the selected instance, tagged with its cycle.
  always @(negedge masterclk) begin
    ev_t ev;
    ev.cyc = 32'(cyc);
    case (mon_sel)
      0:       begin ev.rise = if_a.rise_stb; ev.fall = if_a.fall_stb; end
      1:       begin ev.rise = if_b.rise_stb; ev.fall = if_b.fall_stb; end
      default: begin ev.rise = if_c.rise_stb; ev.fall = if_c.fall_stb; end
    endcase
    if ((ev.rise | ev.fall) != '0) obs_q.push_back(ev);
  end

  function automatic ev_t mk_ev(int c, logic [N-1:0] r, logic [N-1:0] f);
    ev_t e;
    e.cyc  = 32'(c);
    e.rise = r;
    e.fall = f;
    return e;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge masterclk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_a.raw_in = '0;
    if_b.raw_in = '1;
    if_c.raw_in = '0;
    tick(3);
    for (int d = 0; d < 3; d++) begin
      logic [3*N:0] v;
      case (d)
        0:       v = {if_a.cond_out, if_a.rise_stb, if_a.fall_stb, if_a.any_active};
        1:       v = {if_b.cond_out, if_b.rise_stb, if_b.fall_stb, if_b.any_active};
        default: v = {if_c.cond_out, if_c.rise_stb, if_c.fall_stb, if_c.any_active};
      endcase
      checks++;
      if (v !== '0) begin
        errors++;
        $display("FAIL reset_dut%0d: outputs=%h required 0", d, v);
      end
    end
    rst_n = 1'b1;
    obs_q.delete();
    tick(30);
    // Idle inputs (all-high on the active-low instance) must leave everything inactive.
    for (int d = 0; d < 3; d++) begin
      logic [3*N:0] v;
      case (d)
        0:       v = {if_a.cond_out, if_a.rise_stb, if_a.fall_stb, if_a.any_active};
        1:       v = {if_b.cond_out, if_b.rise_stb, if_b.fall_stb, if_b.any_active};
        default: v = {if_c.cond_out, if_c.rise_stb, if_c.fall_stb, if_c.any_active};
      endcase
      checks++;
      if (v !== '0) begin
        errors++;
        $display("FAIL idle_dut%0d: outputs=%h required 0", d, v);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL idle_strobes: %0d strobe events observed, required 0", obs_q.size());
    end
  endtask

  task automatic test_press();
    int t;
    ev_t e, o;
    mon_sel = 0; obs_q.delete(); exp_q.delete();
    if_a.raw_in[0] = 1'b1; t = cyc;
    exp_q.push_back(mk_ev(t + 11, 13'h0001, 13'h0000));
    tick(20);
    checks++;
    if (if_a.cond_out !== 13'h0001) begin
      errors++; $display("FAIL press_level: cond_out=%h required 0001", if_a.cond_out);
    end
    checks++;
    if (if_a.any_active !== 1'b1) begin
      errors++; $display("FAIL press_any: any_active=%b required 1", if_a.any_active);
    end
    if_a.raw_in[0] = 1'b0; t = cyc;
    exp_q.push_back(mk_ev(t + 11, 13'h0000, 13'h0001));
    tick(20);
    checks++;
    if ({if_a.cond_out, if_a.any_active} !== '0) begin
      errors++; $display("FAIL release_level: cond_out=%h any=%b required 0", if_a.cond_out, if_a.any_active);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL press_event: missing, required cyc=%0d rise=%h fall=%h", e.cyc, e.rise, e.fall);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL press_event: cyc=%0d rise=%h fall=%h required cyc=%0d rise=%h fall=%h",
                   o.cyc, o.rise, o.fall, e.cyc, e.rise, e.fall);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL press_extra: %0d unexpected strobe events, required 0", obs_q.size());
    end
  endtask

  task automatic test_bounce();
    int t;
    ev_t e, o;
    mon_sel = 0; obs_q.delete(); exp_q.delete();
    if_a.raw_in[0] = 1'b1; tick(7);
    if_a.raw_in[0] = 1'b0; tick(2);
    if_a.raw_in[0] = 1'b1; t = cyc;
    exp_q.push_back(mk_ev(t + 11, 13'h0001, 13'h0000));
    tick(25);
    if_a.raw_in[0] = 1'b0; t = cyc;
    exp_q.push_back(mk_ev(t + 11, 13'h0000, 13'h0001));
    tick(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL bounce_event: missing, required cyc=%0d rise=%h fall=%h", e.cyc, e.rise, e.fall);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL bounce_event: cyc=%0d rise=%h fall=%h required cyc=%0d rise=%h fall=%h",
                   o.cyc, o.rise, o.fall, e.cyc, e.rise, e.fall);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL bounce_extra: %0d unexpected strobe events, required 0", obs_q.size());
    end
  endtask

  task automatic test_coin();
    int t, hi, first;
    ev_t e, o;
    mon_sel = 0; obs_q.delete(); exp_q.delete();
    // Held coin switch: one pulse only.
    if_a.raw_in[12] = 1'b1; t = cyc; hi = 0; first = -1;
    exp_q.push_back(mk_ev(t + 11, 13'h1000, 13'h0000));
    exp_q.push_back(mk_ev(t + 211, 13'h0000, 13'h1000));
    for (int i = 0; i < 225; i++) begin
      tick(1);
      if (if_a.cond_out[12]) begin
        if (hi == 0) first = cyc;
        hi++;
      end
      if (cyc == t + 200) if_a.raw_in[12] = 1'b0;
    end
    checks++;
    if (hi != 16 || first != t + 11) begin
      errors++; $display("FAIL coin_hold: high %0d cycles from %0d, required 16 from %0d", hi, first, t + 11);
    end
    // Release then re-press so the second press lands while the pulse is still running.
    if_a.raw_in[12] = 1'b1; t = cyc; hi = 0; first = -1;
    exp_q.push_back(mk_ev(t + 11, 13'h1000, 13'h0000));
    exp_q.push_back(mk_ev(t + 19, 13'h0000, 13'h1000));
    exp_q.push_back(mk_ev(t + 27, 13'h1000, 13'h0000));
    exp_q.push_back(mk_ev(t + 51, 13'h0000, 13'h1000));
    for (int i = 0; i < 65; i++) begin
      tick(1);
      if (if_a.cond_out[12]) begin
        if (hi == 0) first = cyc;
        hi++;
      end
      if (cyc == t + 8)  if_a.raw_in[12] = 1'b0;
      if (cyc == t + 16) if_a.raw_in[12] = 1'b1;
      if (cyc == t + 40) if_a.raw_in[12] = 1'b0;
    end
    checks++;
    if (hi != 16 || first != t + 11) begin
      errors++; $display("FAIL coin_retrig: high %0d cycles from %0d, required 16 from %0d", hi, first, t + 11);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL coin_event: missing, required cyc=%0d rise=%h fall=%h", e.cyc, e.rise, e.fall);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL coin_event: cyc=%0d rise=%h fall=%h required cyc=%0d rise=%h fall=%h",
                   o.cyc, o.rise, o.fall, e.cyc, e.rise, e.fall);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL coin_extra: %0d unexpected strobe events, required 0", obs_q.size());
    end
  endtask

  task automatic test_active_low();
    int t;
    ev_t e, o;
    mon_sel = 1; obs_q.delete(); exp_q.delete();
    if_b.raw_in[3] = 1'b0; t = cyc;
    exp_q.push_back(mk_ev(t + 11, 13'h0008, 13'h0000));
    tick(20);
    checks++;
    if ({if_b.cond_out, if_b.any_active} !== {13'h0008, 1'b1}) begin
      errors++; $display("FAIL al_level: cond_out=%h any=%b required 0008/1", if_b.cond_out, if_b.any_active);
    end
    if_b.raw_in[3] = 1'b1; t = cyc;
    exp_q.push_back(mk_ev(t + 11, 13'h0000, 13'h0008));
    tick(20);
    checks++;
    if ({if_b.cond_out, if_b.any_active} !== '0) begin
      errors++; $display("FAIL al_release: cond_out=%h any=%b required 0", if_b.cond_out, if_b.any_active);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL al_event: missing, required cyc=%0d rise=%h fall=%h", e.cyc, e.rise, e.fall);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL al_event: cyc=%0d rise=%h fall=%h required cyc=%0d rise=%h fall=%h",
                   o.cyc, o.rise, o.fall, e.cyc, e.rise, e.fall);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL al_extra: %0d unexpected strobe events, required 0", obs_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int t, r;
    ev_t e, o;
    mon_sel = 0; obs_q.delete(); exp_q.delete();
    if_a.raw_in[12] = 1'b1; t = cyc;
    exp_q.push_back(mk_ev(t + 11, 13'h1000, 13'h0000));
    tick(8);
    if_a.raw_in[0] = 1'b1;
    tick(6);
    checks++;
    if (if_a.cond_out !== 13'h1000) begin
      errors++; $display("FAIL mid_pre: cond_out=%h required 1000", if_a.cond_out);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({if_a.cond_out, if_a.rise_stb, if_a.fall_stb, if_a.any_active} !== '0) begin
      errors++; $display("FAIL mid_reset: cond=%h rise=%h fall=%h any=%b required 0",
                         if_a.cond_out, if_a.rise_stb, if_a.fall_stb, if_a.any_active);
    end
    tick(3);
    rst_n = 1'b1; r = cyc;
    exp_q.push_back(mk_ev(r + 11, 13'h1001, 13'h0000));
    tick(30);
    checks++;
    if ({if_a.cond_out, if_a.any_active} !== {13'h0001, 1'b1}) begin
      errors++; $display("FAIL mid_requal: cond_out=%h any=%b required 0001/1", if_a.cond_out, if_a.any_active);
    end
    if_a.raw_in = '0; t = cyc;
    exp_q.push_back(mk_ev(t + 11, 13'h0000, 13'h1001));
    tick(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL mid_event: missing, required cyc=%0d rise=%h fall=%h", e.cyc, e.rise, e.fall);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL mid_event: cyc=%0d rise=%h fall=%h required cyc=%0d rise=%h fall=%h",
                   o.cyc, o.rise, o.fall, e.cyc, e.rise, e.fall);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL mid_extra: %0d unexpected strobe events, required 0", obs_q.size());
    end
  endtask

  task automatic test_bypass();
    int t;
    ev_t e, o;
    mon_sel = 2; obs_q.delete(); exp_q.delete();
    if_c.raw_in = '1; t = cyc;
    exp_q.push_back(mk_ev(t + 4, 13'h1FFF, 13'h0000));
    exp_q.push_back(mk_ev(t + 5, 13'h0000, 13'h1FFF));
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (cyc == t + 1) if_c.raw_in = '0;
      if (cyc == t + 4) begin
        checks++;
        if ({if_c.cond_out, if_c.any_active} !== {13'h1FFF, 1'b1}) begin
          errors++; $display("FAIL bypass_level: cond_out=%h any=%b required 1fff/1", if_c.cond_out, if_c.any_active);
        end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL bypass_event: missing, required cyc=%0d rise=%h fall=%h", e.cyc, e.rise, e.fall);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL bypass_event: cyc=%0d rise=%h fall=%h required cyc=%0d rise=%h fall=%h",
                   o.cyc, o.rise, o.fall, e.cyc, e.rise, e.fall);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL bypass_extra: %0d unexpected strobe events, required 0", obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_coin();
    test_active_low();
    test_reset_mid();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
